count_arbiter: RTL and testbench

//   Shares the dual 64-bit select counter (Slt/En-driven) between two requesters.

---
 rtl/count_arbiter_pkg.sv | 18 +
 rtl/count_arbiter_rr_arb2.sv | 22 ++
 rtl/count_arbiter.sv | 109 ++++++++++
 tb/tb_count_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_arbiter_pkg.sv
// Shared definitions for the select-counter arbiter: default burst-length
// width and the FSM state encodings.
package count_arbiter_pkg;

   localparam int LEN_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One-hot encode a single-bit requester index.
   function automatic logic [1:0] onehot2(input logic i_idx);
      return i_idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/count_arbiter_rr_arb2.sv
// Two-way round-robin picker. A lone requester wins outright; on a tie the
// requester that was not served last wins.
module rr_arb2
   import count_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   // Combinational pick: tie goes to the requester other than i_last.
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = onehot2(~i_last);
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/count_arbiter.sv
// Arbitrates the shared dual 64-bit select counter between two requesters.
// The winner's burst length is latched at grant, Slt/En are driven for exactly
// that many cycles, then Done pulses to the owner for one cycle.
module count_arbiter
   import count_arbiter_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic [1:0]       Req,
   input  logic [LEN_W-1:0] Len0,
   input  logic [LEN_W-1:0] Len1,
   output logic [1:0]       Gnt,
   output logic [1:0]       Done,
   output logic             Busy,
   output logic             Slt,
   output logic             En
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_gnt;
   logic             r_slt;
   logic             r_last;
   logic [LEN_W-1:0] r_remain;

   logic [1:0]       w_pick;
   logic             w_win;
   logic [LEN_W-1:0] w_len;

   rr_arb2 u_rr_arb2 (
      .i_req  (Req),
      .i_last (r_last),
      .o_gnt  (w_pick)
   );

   // Winner index and its burst length, only meaningful in IDLE with a request.
   assign w_win = w_pick[1];
   assign w_len = w_win ? Len1 : Len0;

   // Next-state decode; a zero-length burst skips RUN entirely.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (|Req) begin
               w_state_nxt = (w_len != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (r_remain == LEN_W'(1)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register; asynchronous reset forces En low immediately.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant, select, remaining-count and round-robin history registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_gnt    <= 2'b00;
         r_slt    <= 1'b0;
         r_remain <= '0;
         r_last   <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|Req) begin
                  r_slt    <= w_win;
                  r_gnt    <= w_pick;
                  r_remain <= w_len;
               end
            end
            ST_RUN: begin
               // Leaves RUN when this reaches zero, so it never wraps.
               r_remain <= r_remain - LEN_W'(1);
            end
            ST_DONE: begin
               r_last <= r_slt;
               r_gnt  <= 2'b00;
            end
            default: begin
               r_gnt <= 2'b00;
            end
         endcase
      end
   end

   // Moore outputs decoded from registers.
   assign Gnt  = r_gnt;
   assign Done = (r_state == ST_DONE) ? r_gnt : 2'b00;
   assign Busy = (r_state != ST_IDLE);
   assign En   = (r_state == ST_RUN);
   assign Slt  = r_slt;

endmodule

// File: tb/tb_count_arbiter.sv
// Scoreboard bench for count_arbiter: per-requester burst queues drive Req/Len,
// a transaction-level model predicts grants, a monitor checks each burst at Done.
module tb_count_arbiter;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [1:0] Req = 2'b00;
   logic [3:0] Len0 = 4'd0;
   logic [3:0] Len1 = 4'd0;
   logic [1:0] Gnt, Done;
   logic       Busy, Slt, En;

   count_arbiter #(.LEN_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Len0(Len0), .Len1(Len1),
      .Gnt(Gnt), .Done(Done), .Busy(Busy), .Slt(Slt), .En(En)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Downstream select counter stand-in.
   longint act_o0 = 0, act_o1 = 0;
   always @(posedge Clk) begin
      if (En) begin
         if (Slt) act_o1 <= act_o1 + 1;
         else     act_o0 <= act_o0 + 1;
      end
   end

   // Pending bursts per requester; head is the length offered on Len.
   int q0[$];
   int q1[$];

   // Driver: retire a burst when its Done is seen, present the next one.
   always @(negedge Clk) begin
      if (!Reset && Done[0] && q0.size() > 0) void'(q0.pop_front());
      if (!Reset && Done[1] && q1.size() > 0) void'(q1.pop_front());
      Req  = {q1.size() != 0, q0.size() != 0};
      Len0 = (q0.size() != 0) ? 4'(q0[0]) : 4'($urandom);
      Len1 = (q1.size() != 0) ? 4'(q1[0]) : 4'($urandom);
   end

   // Reference model: arbiter is free again Len+2 edges after a grant.
   typedef struct { int w; int len; int k; } exp_t;
   exp_t   expq[$];
   int     cyc = 0;
   int     busy_until = 0;
   int     m_last = 1;
   longint exp_o0 = 0, exp_o1 = 0;

   always @(posedge Clk) begin
      if (Reset) begin
         if (expq.size() > 0) begin
            // Burst cut short: only the En cycles before reset reached the counter.
            int el;
            el = cyc - expq[0].k;
            if (el > expq[0].len) el = expq[0].len;
            if (expq[0].w == 1) exp_o1 -= (expq[0].len - el);
            else                exp_o0 -= (expq[0].len - el);
         end
         expq.delete();
         busy_until = 0;
         m_last = 1;
      end else begin
         cyc++;
         if (cyc >= busy_until && Req != 2'b00) begin
            exp_t e;
            if (Req == 2'b11) e.w = 1 - m_last;
            else              e.w = Req[1] ? 1 : 0;
            e.len = (e.w == 1) ? int'(Len1) : int'(Len0);
            e.k = cyc;
            expq.push_back(e);
            if (e.w == 1) exp_o1 += e.len;
            else          exp_o0 += e.len;
            busy_until = cyc + e.len + 2;
            m_last = e.w;
         end
      end
   end

   // Monitor: track the burst from grant to Done and compare with the model.
   int gnt_log[$];
   int in_b = 0, own = 0, cnt = 0, slt_bad = 0, gcyc = 0;

   always @(negedge Clk) begin
      if (Reset) begin
         in_b = 0;
         cnt = 0;
      end else begin
         chk("invariants", int'(($countones(Gnt) > 1) || (En && !Busy) || ((Done & ~Gnt) != 2'b00)), 0);
         if (in_b == 0 && Gnt != 2'b00) begin
            in_b = 1;
            own = Gnt[1] ? 1 : 0;
            cnt = 0;
            slt_bad = 0;
            gcyc = cyc;
         end
         if (En) begin
            cnt++;
            if (in_b == 0 || int'(Slt) != own) slt_bad = 1;
         end
         if (Done != 2'b00) begin
            if (expq.size() == 0) begin
               chk("unexpected_done", int'(Done), 0);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("done_owner", int'(Done), (e.w == 1) ? 2 : 1);
               chk("gnt_at_done", int'(Gnt), (e.w == 1) ? 2 : 1);
               chk("en_cycles", cnt, e.len);
               chk("grant_cycle", gcyc, e.k);
               chk("done_cycle", cyc, e.k + e.len);
               chk("slt_during_en", slt_bad, 0);
               gnt_log.push_back(own);
            end
            in_b = 0;
         end
      end
   end

   task automatic wait_idle(input string name, input int bound);
      int streak = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge Clk);
         if (q0.size() == 0 && q1.size() == 0 && !Busy && expq.size() == 0)
            streak++;
         else
            streak = 0;
         if (streak >= 3) return;
      end
      chk({name, "_timeout"}, 1, 0);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
   endtask

   longint b0, b1;

   task automatic mark();
      b0 = act_o0;
      b1 = act_o1;
      gnt_log.delete();
   endtask

   task automatic check_counts(input string name, input longint d0, input longint d1);
      chk({name, "_out0"}, act_o0 - b0, d0);
      chk({name, "_out1"}, act_o1 - b1, d1);
      chk({name, "_out0_model"}, act_o0, exp_o0);
      chk({name, "_out1_model"}, act_o1, exp_o1);
   endtask

   initial begin
      int exp_order[6];
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e3[6];
      e3 = '{0, 1, 0, 1, 0, 1};

      // Reset state
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_gnt", int'(Gnt), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_en", int'(En), 0);
      chk("rst_slt", int'(Slt), 0);
      @(negedge Clk);
      Reset = 1'b0;

      // 1: single requester 0, length 3
      mark();
      q0.push_back(3);
      wait_idle("t1", 100);
      check_counts("t1", 3, 0);
      chk("t1_nbursts", gnt_log.size(), 1);

      // 2: both from reset, req0 first
      do_reset();
      mark();
      q0.push_back(2);
      q1.push_back(4);
      wait_idle("t2", 100);
      check_counts("t2", 2, 4);
      chk("t2_nbursts", gnt_log.size(), 2);
      if (gnt_log.size() == 2) begin
         chk("t2_first", gnt_log[0], 0);
         chk("t2_second", gnt_log[1], 1);
      end

      // 3: alternating service
      mark();
      repeat (3) begin
         q0.push_back(1);
         q1.push_back(1);
      end
      wait_idle("t3", 200);
      check_counts("t3", 3, 3);
      chk("t3_nbursts", gnt_log.size(), 6);
      if (gnt_log.size() == 6)
         for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), gnt_log[i], e3[i]);

      // 4: zero-length burst
      mark();
      q1.push_back(0);
      wait_idle("t4", 100);
      check_counts("t4", 0, 0);
      chk("t4_nbursts", gnt_log.size(), 1);
      if (gnt_log.size() == 1) chk("t4_owner", gnt_log[0], 1);

      // 5: maximum length
      mark();
      q0.push_back(15);
      wait_idle("t5", 100);
      check_counts("t5", 15, 0);

      // 6: reset in the middle of a burst
      do_reset();
      mark();
      q0.push_back(5);
      begin
         int seen = 0;
         for (int i = 0; i < 50 && seen == 0; i++) begin
            @(negedge Clk);
            if (Gnt != 2'b00) seen = 1;
         end
         chk("t6_grant_seen", seen, 1);
      end
      @(posedge Clk);
      @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("t6_en_drop", int'(En), 0);
      chk("t6_gnt_drop", int'(Gnt), 0);
      chk("t6_busy_drop", int'(Busy), 0);
      chk("t6_no_done", int'(Done), 0);
      q0[0] = 4;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      wait_idle("t6", 100);
      check_counts("t6", 6, 0);
      chk("t6_nbursts", gnt_log.size(), 1);
      if (gnt_log.size() == 1) chk("t6_owner", gnt_log[0], 0);

      // Random traffic
      mark();
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if ($urandom_range(0, 1) == 1) q1.push_back(int'($urandom_range(0, 15)));
         else                           q0.push_back(int'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 20)) @(negedge Clk);
      end
      wait_idle("rand", 2000);
      chk("rand_out0_model", act_o0, exp_o0);
      chk("rand_out1_model", act_o1, exp_o1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
